i_ddr_rx_aligner: RTL and testbench
===================================

Name: i_ddr_rx_aligner

Overview:
Controller for the I_DDR input capture path. It enables the I_DDR primitive and trains word alignment against a known pattern by sweeping bit slip. Once locked, it assembles WORD_W-bit words from the 2-bit-per-cycle DDR stream and delivers them over a valid/ready interface with a 2-entry buffer. It sits between the I_DDR data_reg output and the fabric consumer.

Parameters:
WORD_W, 8, word width in bits; even, 4..32.
TRAIN_PATTERN, 8'hA5, training word (WORD_W bits); must not equal any of its own rotations.
LOCK_COUNT, 4, consecutive matching words required for lock; 1..15.
MAX_MISS, 16, mismatching words tolerated in TRAIN before error; must be at least 2*WORD_W.

Ports:
clk_i  input  1  single clock; same clock that drives I_DDR.
reset_n  input  1  synchronous active-low reset.
start  input  1  pulse; begin training from IDLE or ERROR.
stop  input  1  pulse; abort and return to IDLE.
ddr_data  input  2  I_DDR data_reg; bit0 is the posedge (earlier) bit, bit1 the negedge bit.
ddr_enable  output  1  drives I_DDR enable.
word_o  output  WORD_W  received word; MSB is the first bit received.
word_valid  output  1  word_o holds a word.
word_ready  input  1  consumer accepts word_o when word_valid=1 at the clock edge.
locked  output  1  high in LOCKED.
train_err  output  1  high in ERROR.
overflow  output  1  sticky; a word was dropped because the buffer was full.
slip_o  output  log2(WORD_W)  current bit slip, 0..WORD_W-1.

Behaviour:
- Reset applies on any clk_i edge with reset_n=0, in any state. Outputs after reset: ddr_enable=0, word_o=0, word_valid=0, locked=0, train_err=0, overflow=0, slip_o=0. State goes to IDLE, buffer is emptied, all counters are cleared.
- States: IDLE, FLUSH, TRAIN, LOCKED, ERROR.
- IDLE: ddr_enable=0. start=1 moves to FLUSH and clears slip, match_cnt, miss_cnt and overflow.
- FLUSH: ddr_enable=1. Lasts exactly 2 cycles, to discard I_DDR pipeline contents, then moves to TRAIN.
- ddr_enable=1 in FLUSH, TRAIN and LOCKED. It is 0 in IDLE and ERROR.
- Bit stream: each cycle in TRAIN or LOCKED appends ddr_data[0] and then ddr_data[1] to a history register. The history register holds at least 2*WORD_W bits.
- Word boundary: a word is formed every WORD_W/2 cycles. Its offset into the history is set by slip_o: bit offset is slip_o mod 2, cycle phase is slip_o/2.
- TRAIN, each word:
  - word == TRAIN_PATTERN: match_cnt increments. When match_cnt reaches LOCK_COUNT, move to LOCKED.
  - Otherwise: match_cnt=0, miss_cnt increments, slip_o increments (WORD_W-1 wraps to 0).
  - The first word compared after a slip change is the first complete word at the new alignment. No stale-alignment word is ever compared.
- TRAIN to ERROR: when miss_cnt reaches MAX_MISS, move to ERROR.
- ERROR: train_err=1, ddr_enable=0, slip_o holds. start=1 clears train_err and moves to FLUSH.
- LOCKED:
  - locked=1; slip_o is frozen.
  - Every formed word is pushed into the 2-entry FIFO. No pattern check is done.
  - Latency: a word appears on word_o 1 cycle after its last bit is in ddr_data.
  - word_o and word_valid hold stable until accepted.
  - A push into a full FIFO drops the new word and sets overflow=1. An accept and a push in the same cycle on a full FIFO is not an overflow.
- stop=1 in any state except IDLE: go to IDLE next edge, empty the FIFO, word_valid=0, locked=0, train_err=0. overflow is kept until the next start.
- start and stop high in the same cycle: stop wins.
- start in FLUSH, TRAIN or LOCKED is ignored.
- word_valid is 0 in every state except LOCKED.

Test Plan:
1. Aligned lock: WORD_W=8; send continuous 8'hA5 with the MSB on ddr_data[0] of the first word cycle, start pulse. Expect locked=1 after 2 flush cycles plus 4 words (16 cycles), slip_o=0, train_err=0.
2. Misaligned lock: same stream delayed by 3 bits. Expect slip_o to sweep 0→3, locked=1 with slip_o=3. Then send payload 8'h3C, 8'hC3; word_o must show 3C then C3.
3. Training failure: random data with no A5 at any slip. Expect train_err=1 after 16 mismatched words, ddr_enable=0, locked=0. A following start clears train_err and ddr_enable returns to 1.
4. Backpressure: locked, word_ready=0, words 11, 22, 33 arrive. Expect word_o=11 stable, overflow=1, 33 dropped. Raise word_ready: expect 11 then 22, then word_valid=0.
5. Stop priority: in LOCKED, start and stop high together. Expect IDLE next cycle, ddr_enable=0, word_valid=0, locked=0.
6. Reset mid-operation: reset_n=0 for 1 cycle in TRAIN with slip_o=5. Expect all outputs at reset values and slip_o=0 after that edge, and no training until the next start.

Source files
------------

// File: rtl/i_ddr_rx_aligner.sv
// I_DDR capture controller: flushes the I_DDR pipeline, sweeps bit slip until the
// training word locks, then assembles words into a 2-entry valid/ready buffer.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | I_DDR disabled, waiting for start
// ST_FLUSH  | I_DDR enabled, discarding 2 cycles of pipeline contents
// ST_TRAIN  | comparing words to TRAIN_PATTERN, slipping on every miss
// ST_LOCKED | alignment frozen, every word pushed into the buffer
// ST_ERROR  | training gave up; I_DDR disabled until the next start
module i_ddr_rx_aligner #(
   parameter int                WORD_W        = 8,
   parameter logic [WORD_W-1:0] TRAIN_PATTERN = 8'hA5,
   parameter int                LOCK_COUNT    = 4,
   parameter int                MAX_MISS      = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      stop,
   input  logic [1:0]                ddr_data,
   output logic                      ddr_enable,
   output logic [WORD_W-1:0]         word_o,
   output logic                      word_valid,
   input  logic                      word_ready,
   output logic                      locked,
   output logic                      train_err,
   output logic                      overflow,
   output logic [$clog2(WORD_W)-1:0] slip_o
);

   localparam int SLIP_W = $clog2(WORD_W);
   localparam int TMR_W  = $clog2(WORD_W);
   localparam int HIST_W = 2 * WORD_W;
   localparam int MISS_W = $clog2(MAX_MISS + 1);

   localparam logic [TMR_W-1:0]  WORD_RELOAD = TMR_W'(WORD_W / 2 - 1);
   localparam logic [TMR_W-1:0]  FLUSH_LOAD  = TMR_W'(1);
   localparam logic [SLIP_W-1:0] SLIP_LAST   = SLIP_W'(WORD_W - 1);
   localparam logic [3:0]        MATCH_LAST  = 4'(LOCK_COUNT - 1);
   localparam logic [MISS_W-1:0] MISS_LAST   = MISS_W'(MAX_MISS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_TRAIN,
      ST_LOCKED,
      ST_ERROR
   } state_t;

   state_t              state_q,  state_d;
   logic [TMR_W-1:0]    tmr_q,    tmr_d;
   logic [SLIP_W-1:0]   slip_q,   slip_d;
   logic [3:0]          match_q,  match_d;
   logic [MISS_W-1:0]   miss_q,   miss_d;
   logic [HIST_W-1:0]   hist_q,   hist_d;
   logic                ovf_q,    ovf_d;
   logic [WORD_W-1:0]   fifo0_q,  fifo0_d;
   logic [WORD_W-1:0]   fifo1_q,  fifo1_d;
   logic [1:0]          cnt_q,    cnt_d;

   logic                shift_en;
   logic [HIST_W-1:0]   hist_shift;
   logic [WORD_W-1:0]   word_cur;
   logic                word_evt;
   logic                pop;
   logic                hist_unused;

   // Newest bit sits at index 0; an odd slip ends the word on the posedge bit.
   assign shift_en    = (state_q == ST_TRAIN) || (state_q == ST_LOCKED);
   assign hist_shift  = {hist_q[HIST_W-3:0], ddr_data[0], ddr_data[1]};
   assign word_cur    = slip_q[0] ? hist_shift[WORD_W:1] : hist_shift[WORD_W-1:0];
   assign word_evt    = shift_en && (tmr_q == '0);
   assign hist_unused = ^hist_q[HIST_W-1 -: 2];

   assign ddr_enable  = (state_q == ST_FLUSH) || shift_en;
   assign locked      = (state_q == ST_LOCKED);
   assign train_err   = (state_q == ST_ERROR);
   assign overflow    = ovf_q;
   assign slip_o      = slip_q;
   assign word_o      = fifo0_q;
   assign word_valid  = (cnt_q != 2'd0);
   assign pop         = word_valid && word_ready;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      slip_d  = slip_q;
      match_d = match_q;
      miss_d  = miss_q;
      ovf_d   = ovf_q;
      fifo0_d = fifo0_q;
      fifo1_d = fifo1_q;
      cnt_d   = cnt_q;
      hist_d  = shift_en ? hist_shift : hist_q;

      if (stop) begin
         state_d = ST_IDLE;
         cnt_d   = 2'd0;
      end else begin
         if (pop) begin
            fifo0_d = fifo1_q;
            cnt_d   = cnt_q - 2'd1;
         end
         case (state_q)
            ST_IDLE, ST_ERROR: begin
               if (start) begin
                  state_d = ST_FLUSH;
                  tmr_d   = FLUSH_LOAD;
                  slip_d  = '0;
                  match_d = '0;
                  miss_d  = '0;
                  ovf_d   = 1'b0;
               end
            end
            ST_FLUSH: begin
               if (tmr_q == '0) begin
                  state_d = ST_TRAIN;
                  tmr_d   = WORD_RELOAD;
               end else begin
                  tmr_d = tmr_q - TMR_W'(1);
               end
            end
            ST_TRAIN: begin
               if (!word_evt) begin
                  tmr_d = tmr_q - TMR_W'(1);
               end else if (word_cur == TRAIN_PATTERN) begin
                  tmr_d = WORD_RELOAD;
                  if (match_q == MATCH_LAST) state_d = ST_LOCKED;
                  else                       match_d = match_q + 4'd1;
               end else begin
                  // Next word ends one bit later: next cycle if this one ended on
                  // the negedge bit, otherwise a full word later (same-cycle word skipped).
                  match_d = '0;
                  miss_d  = miss_q + MISS_W'(1);
                  slip_d  = (slip_q == SLIP_LAST) ? '0 : slip_q + SLIP_W'(1);
                  tmr_d   = slip_q[0] ? WORD_RELOAD : '0;
                  if (miss_q == MISS_LAST) state_d = ST_ERROR;
               end
            end
            ST_LOCKED: begin
               if (!word_evt) begin
                  tmr_d = tmr_q - TMR_W'(1);
               end else begin
                  tmr_d = WORD_RELOAD;
                  if (cnt_d != 2'd2) begin
                     if (cnt_d == 2'd0) fifo0_d = word_cur;
                     else               fifo1_d = word_cur;
                     cnt_d = cnt_d + 2'd1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         slip_q  <= '0;
         match_q <= '0;
         miss_q  <= '0;
         hist_q  <= '0;
         ovf_q   <= 1'b0;
         fifo0_q <= '0;
         fifo1_q <= '0;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         slip_q  <= slip_d;
         match_q <= match_d;
         miss_q  <= miss_d;
         hist_q  <= hist_d;
         ovf_q   <= ovf_d;
         fifo0_q <= fifo0_d;
         fifo1_q <= fifo1_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_i_ddr_rx_aligner.sv
// Bench for i_ddr_rx_aligner: bit-queue reference model checked every cycle,
// plus directed checks for lock timing, slip sweep, failure, backpressure and reset.
module tb_i_ddr_rx_aligner;

   localparam int         W     = 8;
   localparam logic [7:0] PAT   = 8'hA5;
   localparam int         LOCKN = 4;
   localparam int         MAXM  = 16;

   localparam int M_IDLE = 0, M_FLUSH = 1, M_TRAIN = 2, M_LOCK = 3, M_ERR = 4;

   logic       clk_i = 1'b0;
   logic       reset_n, start, stop, word_ready;
   logic [1:0] ddr_data;
   logic       ddr_enable, word_valid, locked, train_err, overflow;
   logic [7:0] word_o;
   logic [2:0] slip_o;

   always #5 clk_i = ~clk_i;

   i_ddr_rx_aligner dut (
      .clk_i      (clk_i),
      .reset_n    (reset_n),
      .start      (start),
      .stop       (stop),
      .ddr_data   (ddr_data),
      .ddr_enable (ddr_enable),
      .word_o     (word_o),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .locked     (locked),
      .train_err  (train_err),
      .overflow   (overflow),
      .slip_o     (slip_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference model: stream bits since entering TRAIN, end index of the next word
   int         m_st, m_flush, m_slip, m_match, m_miss, m_end;
   bit         m_ovf;
   bit         bits[$];
   logic [7:0] fifo[$];
   bit         tx[$];
   bit         fill_ones;
   logic [7:0] rx[$];

   task automatic model_step();
      bit         do_pop;
      logic [7:0] w;
      do_pop = (fifo.size() > 0) && word_ready;
      if (!reset_n) begin
         m_st = M_IDLE; m_slip = 0; m_match = 0; m_miss = 0; m_ovf = 0;
         fifo.delete(); bits.delete();
      end else if (stop) begin
         m_st = M_IDLE;
         fifo.delete();
      end else begin
         if (do_pop) void'(fifo.pop_front());
         case (m_st)
            M_IDLE, M_ERR: if (start) begin
               m_st = M_FLUSH; m_flush = 2; m_slip = 0; m_match = 0; m_miss = 0; m_ovf = 0;
            end
            M_FLUSH: begin
               m_flush--;
               if (m_flush == 0) begin m_st = M_TRAIN; bits.delete(); m_end = W - 1; end
            end
            M_TRAIN, M_LOCK: begin
               bits.push_back(ddr_data[0]);
               bits.push_back(ddr_data[1]);
               if (m_end < bits.size()) begin
                  for (int i = 0; i < W; i++) w[W-1-i] = bits[m_end-W+1+i];
                  if (m_st == M_LOCK) begin
                     if (fifo.size() < 2) fifo.push_back(w);
                     else                 m_ovf = 1;
                     m_end += W;
                  end else if (w == PAT) begin
                     m_match++;
                     m_end += W;
                     if (m_match == LOCKN) m_st = M_LOCK;
                  end else begin
                     m_match = 0;
                     m_miss++;
                     m_slip = (m_slip + 1) % W;
                     // an end on an odd index finished its cycle; an even one shares it
                     m_end += (m_end % 2 == 1) ? 1 : W + 1;
                     if (m_miss == MAXM) m_st = M_ERR;
                  end
               end
            end
            default: m_st = M_IDLE;
         endcase
      end
   endtask

   function automatic logic [31:0] dut_status();
      return {24'b0, ddr_enable, locked, train_err, overflow, word_valid, slip_o};
   endfunction

   function automatic logic [31:0] exp_status();
      logic en;
      en = (m_st == M_FLUSH) || (m_st == M_TRAIN) || (m_st == M_LOCK);
      return {24'b0, en, m_st == M_LOCK, m_st == M_ERR, m_ovf, fifo.size() > 0, 3'(m_slip)};
   endfunction

   task automatic push_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) tx.push_back(w[i]);
   endtask

   task automatic tick();
      if (m_st == M_TRAIN || m_st == M_LOCK) begin
         if (tx.size() >= 2) begin
            ddr_data[0] = tx.pop_front();
            ddr_data[1] = tx.pop_front();
         end else if (fill_ones) begin
            ddr_data = {1'($urandom_range(0, 1)), 1'b1};
         end else begin
            ddr_data = 2'($urandom);
         end
      end else begin
         ddr_data = 2'($urandom);
      end
      if (word_valid && word_ready) rx.push_back(word_o);
      model_step();
      @(posedge clk_i);
      #1;
      check_val("status", dut_status(), exp_status());
      if (fifo.size() > 0) check_val("word", 32'(word_o), 32'(fifo[0]));
   endtask

   task automatic wait_locked(output int n);
      n = 0;
      while (!locked && n < 200) begin tick(); n++; end
   endtask

   int n, k, d;

   initial begin
      reset_n = 1'b0; start = 1'b0; stop = 1'b0; word_ready = 1'b1;
      ddr_data = 2'b00; fill_ones = 1'b0;
      m_st = M_IDLE; m_flush = 0; m_slip = 0; m_match = 0; m_miss = 0; m_end = 0; m_ovf = 0;
      tick(); tick();
      check_val("rst_status", dut_status(), 32'h0);
      check_val("rst_word", 32'(word_o), 32'h0);
      reset_n = 1'b1;
      tick();

      // aligned lock
      tx.delete(); repeat (12) push_word(PAT);
      start = 1'b1; tick(); start = 1'b0;
      wait_locked(n);
      check_val("t1_lock_cycles", n, 18);
      check_val("t1_slip", 32'(slip_o), 0);
      check_val("t1_err", 32'(train_err), 0);

      // lock through a 3-bit delay, then payload
      stop = 1'b1; tick(); stop = 1'b0;
      tx.delete();
      repeat (3) tx.push_back(1'b0);
      repeat (10) push_word(PAT);
      push_word(8'h3C); push_word(8'hC3);
      repeat (4) push_word(PAT);
      start = 1'b1; tick(); start = 1'b0;
      wait_locked(n);
      check_val("t2_locked", 32'(locked), 1);
      check_val("t2_slip", 32'(slip_o), 3);
      rx.delete();
      repeat (80) tick();
      k = 0;
      while (k < rx.size() && rx[k] == PAT) k++;
      check_val("t2_pay0", (k < rx.size()) ? 32'(rx[k]) : 32'h0, 32'h3C);
      check_val("t2_pay1", (k + 1 < rx.size()) ? 32'(rx[k+1]) : 32'h0, 32'hC3);

      // training failure: stream never holds two adjacent zeros, so no A5 anywhere
      stop = 1'b1; tick(); stop = 1'b0;
      tx.delete(); fill_ones = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (!train_err && n < 300) begin tick(); n++; end
      check_val("t3_err_cycles", n, 42);
      check_val("t3_err", 32'(train_err), 1);
      check_val("t3_en_off", 32'(ddr_enable), 0);
      check_val("t3_unlocked", 32'(locked), 0);
      start = 1'b1; tick(); start = 1'b0;
      check_val("t3_err_clear", 32'(train_err), 0);
      check_val("t3_en_on", 32'(ddr_enable), 1);

      // backpressure
      stop = 1'b1; tick(); stop = 1'b0;
      fill_ones = 1'b0; tx.delete(); repeat (4) push_word(PAT);
      word_ready = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      wait_locked(n);
      check_val("t4_lock_cycles", n, 18);
      push_word(8'h11); push_word(8'h22); push_word(8'h33);
      repeat (4) tick();
      check_val("t4_first", 32'(word_o), 32'h11);
      repeat (4) tick();
      check_val("t4_hold", 32'(word_o), 32'h11);
      check_val("t4_no_ovf_yet", 32'(overflow), 0);
      repeat (4) tick();
      check_val("t4_hold2", 32'(word_o), 32'h11);
      check_val("t4_ovf", 32'(overflow), 1);
      rx.delete(); word_ready = 1'b1;
      tick(); tick();
      check_val("t4_rx0", (rx.size() > 0) ? 32'(rx[0]) : 32'h0, 32'h11);
      check_val("t4_rx1", (rx.size() > 1) ? 32'(rx[1]) : 32'h0, 32'h22);
      check_val("t4_drained", 32'(word_valid), 0);

      // stop beats start
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      check_val("t5_en", 32'(ddr_enable), 0);
      check_val("t5_valid", 32'(word_valid), 0);
      check_val("t5_locked", 32'(locked), 0);
      check_val("t5_ovf_kept", 32'(overflow), 1);
      tick();
      check_val("t5_stay_idle", 32'(ddr_enable), 0);

      // reset mid-training at slip 5
      tx.delete(); fill_ones = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (!(m_st == M_TRAIN && m_slip == 5) && n < 200) begin tick(); n++; end
      check_val("t6_slip5", 32'(slip_o), 5);
      reset_n = 1'b0; tick(); reset_n = 1'b1;
      check_val("t6_rst_status", dut_status(), 32'h0);
      check_val("t6_rst_word", 32'(word_o), 32'h0);
      repeat (10) tick();
      check_val("t6_no_train", 32'(ddr_enable), 0);

      // randomized delays, payloads and consumer stalls
      fill_ones = 1'b0;
      for (int r = 0; r < 6; r++) begin
         stop = 1'b1; tick(); stop = 1'b0;
         tx.delete();
         d = $urandom_range(0, 7);
         repeat (d) tx.push_back(1'b0);
         repeat (12) push_word(PAT);
         repeat (12) push_word(8'($urandom));
         start = 1'b1; tick(); start = 1'b0;
         repeat (150) begin
            word_ready = 1'($urandom_range(0, 1));
            tick();
         end
         word_ready = 1'b1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
